umpire_signal_encoder: RTL and testbench

Front end of the ball-tracking path. Turns four raw umpire pushbuttons (legal delivery, wide, no-ball, dead ball) into clean single-cycle event pulses. Its `ball_bowled` output directly drives the `ball_bowled` input of the ball counter, and it pulses only for legal deliveries. Extras and dead balls are reported on separate outputs, so the counter never sees them.

---
 rtl/cricket_pkg.sv | 43 ++++
 rtl/button_debouncer.sv | 49 ++++
 rtl/umpire_signal_encoder.sv | 118 +++++++++++
 tb/tb_umpire_signal_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cricket_pkg.sv
// Shared types and constants for the ball-tracking path.
package cricket_pkg;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned NUM_BTN    = 4;
    localparam int unsigned BTN_LEGAL  = 0;
    localparam int unsigned BTN_WIDE   = 1;
    localparam int unsigned BTN_NOBALL = 2;
    localparam int unsigned BTN_DEAD   = 3;

    localparam logic [1:0] EXTRA_NONE   = 2'b00;
    localparam logic [1:0] EXTRA_WIDE   = 2'b01;
    localparam logic [1:0] EXTRA_NOBALL = 2'b10;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_LEGAL,
        EV_WIDE,
        EV_NOBALL,
        EV_DEAD
    } umpire_event_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKOUT
    } umpire_state_t;

    // Same-cycle presses resolve dead > no-ball > wide > legal.
    function automatic umpire_event_t decode_event(input logic [NUM_BTN-1:0] press);
        umpire_event_t ev;
        ev = EV_NONE;
        if (press[BTN_DEAD])
            ev = EV_DEAD;
        else if (press[BTN_NOBALL])
            ev = EV_NOBALL;
        else if (press[BTN_WIDE])
            ev = EV_WIDE;
        else if (press[BTN_LEGAL])
            ev = EV_LEGAL;
        return ev;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton front end: 2-flop synchronizer, stable-count debouncer and
// registered rising-edge detect.
module button_debouncer
    import cricket_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Count only while the synchronized value disagrees; any bounce restarts.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/umpire_signal_encoder.sv
// Umpire pushbuttons to single-cycle delivery events with post-event lockout.
// Optional UMPIRE_EXTRAS_COUNT_EN adds saturating wide/no-ball counters.
module umpire_signal_encoder
    import cricket_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_legal,
    input  logic       btn_wide,
    input  logic       btn_noball,
    input  logic       btn_dead,
    output logic       ball_bowled,
    output logic       extra_valid,
    output logic [1:0] extra_type,
    output logic       dead_ball,
    output logic       busy
`ifdef UMPIRE_EXTRAS_COUNT_EN
    ,
    output logic [7:0] wide_count,
    output logic [7:0] noball_count
`endif
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    umpire_state_t    state;
    umpire_state_t    state_next;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_next;
    umpire_event_t    ev;

    assign btn_raw = {btn_dead, btn_noball, btn_wide, btn_legal};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[g]),
            .level(level[g]),
            .press(press[g])
        );
    end

    // Next-state, gap counter and event decode.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        ev         = EV_NONE;
        case (state)
            ST_IDLE: begin
                gap_next = '0;
                ev       = decode_event(press);
                if (ev != EV_NONE)
                    state_next = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (|level) begin
                    gap_next = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                gap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            ball_bowled <= 1'b0;
            extra_valid <= 1'b0;
            extra_type  <= EXTRA_NONE;
            dead_ball   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            gap_cnt     <= gap_next;
            ball_bowled <= (ev == EV_LEGAL);
            extra_valid <= (ev == EV_WIDE) || (ev == EV_NOBALL);
            extra_type  <= (ev == EV_WIDE)   ? EXTRA_WIDE   :
                           (ev == EV_NOBALL) ? EXTRA_NOBALL : EXTRA_NONE;
            dead_ball   <= (ev == EV_DEAD);
            busy        <= (state_next == ST_LOCKOUT);
        end
    end

`ifdef UMPIRE_EXTRAS_COUNT_EN
    // Extras tallies saturate; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wide_count   <= '0;
            noball_count <= '0;
        end else begin
            if ((ev == EV_WIDE) && (wide_count != 8'hFF))
                wide_count <= wide_count + 8'd1;
            if ((ev == EV_NOBALL) && (noball_count != 8'hFF))
                noball_count <= noball_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_umpire_signal_encoder.sv
// Directed bench for umpire_signal_encoder at default parameters.
module tb_umpire_signal_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_legal = 1'b0;
    logic       btn_wide = 1'b0;
    logic       btn_noball = 1'b0;
    logic       btn_dead = 1'b0;
    logic       ball_bowled;
    logic       extra_valid;
    logic [1:0] extra_type;
    logic       dead_ball;
    logic       busy;
`ifdef UMPIRE_EXTRAS_COUNT_EN
    logic [7:0] wide_count;
    logic [7:0] noball_count;
`endif

    int checks = 0;
    int errors = 0;

    int         n_ball = 0;
    int         n_extra = 0;
    int         n_dead = 0;
    int         viol = 0;
    logic [1:0] last_type = 2'b00;
    logic       p_ball = 1'b0;
    logic       p_extra = 1'b0;
    logic       p_dead = 1'b0;

    typedef struct {
        string      name;
        logic [3:0] mask;   // {dead, noball, wide, legal}
        bit         bounce;
        int         eb;
        int         ee;
        int         ed;
        int         et;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    umpire_signal_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .btn_legal  (btn_legal),
        .btn_wide   (btn_wide),
        .btn_noball (btn_noball),
        .btn_dead   (btn_dead),
        .ball_bowled(ball_bowled),
        .extra_valid(extra_valid),
        .extra_type (extra_type),
        .dead_ball  (dead_ball),
        .busy       (busy)
`ifdef UMPIRE_EXTRAS_COUNT_EN
        ,
        .wide_count  (wide_count),
        .noball_count(noball_count)
`endif
    );

    function automatic int bad_now();
        int b;
        b = 0;
        if (int'(ball_bowled) + int'(extra_valid) + int'(dead_ball) > 1) b++;
        if (!extra_valid && (extra_type != 2'b00)) b++;
        if ((ball_bowled || extra_valid || dead_ball) && !busy) b++;
        if ((ball_bowled && p_ball) || (extra_valid && p_extra) || (dead_ball && p_dead)) b++;
        return b;
    endfunction

    // Output protocol monitor and pulse tallies.
    always @(negedge clk) begin
        if (!reset) begin
            p_ball  <= 1'b0;
            p_extra <= 1'b0;
            p_dead  <= 1'b0;
        end else begin
            viol    <= viol + bad_now();
            n_ball  <= n_ball + int'(ball_bowled);
            n_extra <= n_extra + int'(extra_valid);
            n_dead  <= n_dead + int'(dead_ball);
            if (extra_valid) last_type <= extra_type;
            p_ball  <= ball_bowled;
            p_extra <= extra_valid;
            p_dead  <= dead_ball;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m);
        {btn_dead, btn_noball, btn_wide, btn_legal} = m;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, " idle"}, int'(busy), 0);
    endtask

    // Press, measure event latency, hold, release, measure busy fall.
    task automatic run_vec(input vec_t v);
        int b0, e0, d0, k;
        bit found;
        b0 = n_ball;
        e0 = n_extra;
        d0 = n_dead;
        @(negedge clk);
        if (v.bounce) begin
            drive(v.mask);
            @(negedge clk);
            drive(4'b0000);
            @(negedge clk);
        end
        drive(v.mask);
        k = 0;
        found = 1'b0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (ball_bowled || extra_valid || dead_ball) found = 1'b1;
        end
        chk({v.name, " latency"}, found ? k : -1, 8);
        while (k < 12) begin
            @(negedge clk);
            k++;
        end
        drive(4'b0000);
        k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({v.name, " busy fall"}, busy ? -1 : k, 14);
        chk({v.name, " ball"}, n_ball - b0, v.eb);
        chk({v.name, " extra"}, n_extra - e0, v.ee);
        chk({v.name, " dead"}, n_dead - d0, v.ed);
        if (v.ee != 0) chk({v.name, " type"}, int'(last_type), v.et);
    endtask

    initial begin
        int b0, e0, k;
        bit found;

        vecs[0] = '{"legal",        4'b0001, 1'b0, 1, 0, 0, 0};
        vecs[1] = '{"wide",         4'b0010, 1'b0, 0, 1, 0, 1};
        vecs[2] = '{"noball",       4'b0100, 1'b0, 0, 1, 0, 2};
        vecs[3] = '{"dead",         4'b1000, 1'b0, 0, 0, 1, 0};
        vecs[4] = '{"legal+noball", 4'b0101, 1'b0, 0, 1, 0, 2};
        vecs[5] = '{"wide bounce",  4'b0010, 1'b1, 0, 1, 0, 1};
        vecs[6] = '{"all four",     4'b1111, 1'b0, 0, 0, 1, 0};
        vecs[7] = '{"wide+legal",   4'b0011, 1'b0, 0, 1, 0, 1};
        vecs[8] = '{"noball+wide",  4'b0110, 1'b0, 0, 1, 0, 2};
        vecs[9] = '{"dead+legal",   4'b1001, 1'b0, 0, 0, 1, 0};

        // Reset held while buttons toggle.
        for (int i = 0; i < 4; i++) begin
            #5;
            drive(4'($urandom));
        end
        chk("reset outputs", int'({ball_bowled, extra_valid, extra_type, dead_ball, busy}), 0);
        drive(4'b0000);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("quiet after reset", n_ball + n_extra + n_dead, 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Re-press before the gap elapses gives nothing; a fresh press after it does.
        b0 = n_ball;
        @(negedge clk);
        drive(4'b0001);
        repeat (12) @(negedge clk);
        drive(4'b0000);
        repeat (3) @(negedge clk);
        drive(4'b0001);
        repeat (5) @(negedge clk);
        drive(4'b0000);
        wait_idle("repress");
        drive(4'b0001);
        repeat (12) @(negedge clk);
        drive(4'b0000);
        wait_idle("fresh");
        chk("lockout repress balls", n_ball - b0, 2);

        b0 = n_ball;
        for (int i = 0; i < 6; i++) run_vec(vecs[0]);
        chk("six legal balls", n_ball - b0, 6);

        // A held button yields a single event.
        b0 = n_ball;
        drive(4'b0001);
        repeat (40) @(negedge clk);
        drive(4'b0000);
        wait_idle("held");
        chk("held single ball", n_ball - b0, 1);

        // A press debounced inside lockout is lost.
        b0 = n_ball;
        e0 = n_extra;
        drive(4'b0001);
        repeat (12) @(negedge clk);
        drive(4'b0000);
        repeat (4) @(negedge clk);
        drive(4'b0010);
        repeat (8) @(negedge clk);
        drive(4'b0000);
        wait_idle("lost");
        chk("lost press ball", n_ball - b0, 1);
        chk("lost press extra", n_extra - e0, 0);

        // Reset mid-lockout with the button still held.
        drive(4'b0001);
        k = 0;
        found = 1'b0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (ball_bowled) found = 1'b1;
        end
        chk("pre-reset pulse", int'(found), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid-lockout reset outputs", int'({ball_bowled, extra_valid, extra_type, dead_ball, busy}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        found = 1'b0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (ball_bowled) found = 1'b1;
        end
        chk("held through reset latency", found ? k : -1, 8);
        repeat (4) @(negedge clk);
        drive(4'b0000);
        wait_idle("after reset");

`ifdef UMPIRE_EXTRAS_COUNT_EN
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(4'b0010);
            repeat (12) @(negedge clk);
            drive(4'b0000);
            wait_idle("wide burst");
        end
        chk("wide_count saturated", int'(wide_count), 255);
        chk("noball_count", int'(noball_count), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("wide_count after reset", int'(wide_count), 0);
        chk("noball_count after reset", int'(noball_count), 0);
        @(negedge clk);
        reset = 1'b1;
`endif

        repeat (2) @(negedge clk);
        chk("protocol violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
